// File: rtl/ltc_decoder.sv
// Biphase-mark LTC decoder: recovers SMPTE timecode, a frame strobe and lock status.
// Define LTC_USER_BITS_EN to add the 32-bit user_bits output.
module ltc_decoder #(
  parameter logic [15:0] THRESH  = 16'd12,
  parameter logic [15:0] TIMEOUT = 16'd64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ltc_in,
  output logic [5:0]  tc_hours,
  output logic [6:0]  tc_min,
  output logic [6:0]  tc_sec,
  output logic [5:0]  tc_frames,
  output logic        drop_frame,
  output logic        frame_valid,
  output logic        locked
`ifdef LTC_USER_BITS_EN
  ,
  output logic [31:0] user_bits
`endif
);

  typedef enum logic [1:0] {IDLE, BIT, HALF} st_t;

  st_t         st_q, st_d;
  logic        s1_q, s2_q, s3_q;
  logic [15:0] cnt_q, cnt_d, ival;
  logic [79:0] sr_q, sr_d;
  logic        bdone_q;
  logic [6:0]  bcnt_q, bcnt_d;
  logic        lock_q, lock_d, fv_q;
  logic [26:0] tc_q, tc_d;
  logic        edg, tmo, glitch, short_i, long_i;
  logic        bit_v, bit_val, err;
  logic        sync, bcd_ok, accept, lost;

  // ival is the saturated count including the current cycle
  assign edg     = s2_q ^ s3_q;
  assign ival    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign cnt_d   = edg ? 16'd0 : ival;
  assign tmo     = !edg && (cnt_q > TIMEOUT);
  assign glitch  = ival < (THRESH >> 2);
  assign short_i = !glitch && (ival < THRESH);
  assign long_i  = (ival >= THRESH) && (ival <= TIMEOUT);

  always_comb begin
    st_d    = st_q;
    bit_v   = 1'b0;
    bit_val = 1'b0;
    err     = 1'b0;
    if (tmo) begin
      st_d = IDLE;
    end else if (edg) begin
      unique case (st_q)
        IDLE: st_d = BIT;
        BIT: begin
          if (long_i)       bit_v = 1'b1;
          else if (short_i) st_d  = HALF;
          else              err   = 1'b1;
        end
        HALF: begin
          st_d = BIT;
          if (short_i) begin
            bit_v   = 1'b1;
            bit_val = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  assign sr_d   = bit_v ? {bit_val, sr_q[79:1]} : sr_q;
  assign sync   = bdone_q && (sr_q[79:64] == 16'hBFFC);
  assign bcd_ok = (sr_q[3:0] <= 4'd9) && (sr_q[19:16] <= 4'd9) &&
                  (sr_q[35:32] <= 4'd9) && (sr_q[51:48] <= 4'd9);
  // a decode error in the sync cycle wins over the frame
  assign accept = sync && !err && bcd_ok;
  assign lost   = err || (sync && !bcd_ok) || (bcnt_q >= 7'd81) || tmo;
  assign lock_d = accept ? 1'b1 : (lost ? 1'b0 : lock_q);

  always_comb begin
    bcnt_d = bcnt_q;
    if (tmo || sync)
      bcnt_d = 7'd0;
    else if (bit_v && (bcnt_q != 7'h7F))
      bcnt_d = bcnt_q + 7'd1;
  end

  assign tc_d = accept ? {sr_q[10], sr_q[57:56], sr_q[51:48],
                          sr_q[42:40], sr_q[35:32], sr_q[26:24],
                          sr_q[19:16], sr_q[9:8], sr_q[3:0]} : tc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= 16'd0;
      st_q    <= IDLE;
      sr_q    <= 80'd0;
      bdone_q <= 1'b0;
      bcnt_q  <= 7'd0;
      lock_q  <= 1'b0;
      fv_q    <= 1'b0;
      tc_q    <= 27'd0;
    end else begin
      s1_q    <= ltc_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      sr_q    <= sr_d;
      bdone_q <= bit_v;
      bcnt_q  <= bcnt_d;
      lock_q  <= lock_d;
      fv_q    <= accept;
      tc_q    <= tc_d;
    end
  end

  assign {drop_frame, tc_hours, tc_min, tc_sec, tc_frames} = tc_q;
  assign frame_valid = fv_q;
  assign locked      = lock_q;

`ifdef LTC_USER_BITS_EN
  logic [31:0] ub_q, ub_d;
  logic        unused_bits;

  assign ub_d = accept ? {sr_q[63:60], sr_q[55:52], sr_q[47:44],
                          sr_q[39:36], sr_q[31:28], sr_q[23:20],
                          sr_q[15:12], sr_q[7:4]} : ub_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ub_q <= 32'd0;
    else          ub_q <= ub_d;
  end

  assign user_bits   = ub_q;
  assign unused_bits = ^{sr_q[59:58], sr_q[43], sr_q[27], sr_q[11]};
`else
  logic unused_bits;
  assign unused_bits = ^{sr_q[63:58], sr_q[55:52], sr_q[47:43],
                         sr_q[39:36], sr_q[31:27], sr_q[23:20],
                         sr_q[15:11], sr_q[7:4]};
`endif

endmodule

// File: tb/tb_ltc_decoder.sv
// Self-checking bench for ltc_decoder: biphase-mark frames at 16 clk/bit
// compared against a frame-level model of the timecode fields.
module tb_ltc_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ltc_in;
  logic [5:0]  tc_hours;
  logic [6:0]  tc_min;
  logic [6:0]  tc_sec;
  logic [5:0]  tc_frames;
  logic        drop_frame;
  logic        frame_valid;
  logic        locked;
`ifdef LTC_USER_BITS_EN
  logic [31:0] user_bits;
`endif

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          fv_cnt = 0;
  int          edge_cyc = 0;
  int          fv_cyc[$];
  logic [26:0] cap[$];
  logic [26:0] last_exp;

  ltc_decoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ltc_in     (ltc_in),
    .tc_hours   (tc_hours),
    .tc_min     (tc_min),
    .tc_sec     (tc_sec),
    .tc_frames  (tc_frames),
    .drop_frame (drop_frame),
    .frame_valid(frame_valid),
    .locked     (locked)
`ifdef LTC_USER_BITS_EN
    ,
    .user_bits  (user_bits)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      fv_cyc.push_back(cyc);
      cap.push_back({drop_frame, tc_hours, tc_min, tc_sec, tc_frames});
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [26:0] obs();
    return {drop_frame, tc_hours, tc_min, tc_sec, tc_frames};
  endfunction

  // expected outputs straight from the decimal time
  function automatic logic [26:0] tcv(int h, int m, int s, int f, bit df);
    return {df, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), 2'(f / 10), 4'(f % 10)};
  endfunction

  function automatic logic [79:0] mk_frame(int h, int m, int s, int f,
                                           bit df, logic [31:0] ub);
    logic [79:0] fr;
    fr = '0;
    fr[3:0]   = 4'(f % 10);
    fr[9:8]   = 2'(f / 10);
    fr[10]    = df;
    fr[19:16] = 4'(s % 10);
    fr[26:24] = 3'(s / 10);
    fr[35:32] = 4'(m % 10);
    fr[42:40] = 3'(m / 10);
    fr[51:48] = 4'(h % 10);
    fr[57:56] = 2'(h / 10);
    for (int k = 0; k < 8; k++) fr[4 + 8 * k +: 4] = ub[4 * k +: 4];
    fr[79:64] = 16'hBFFC;
    return fr;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(bit b);
    ltc_in = ~ltc_in;
    tick(8);
    if (b) ltc_in = ~ltc_in;
    tick(8);
  endtask

  task automatic send_frame(logic [79:0] fr);
    for (int i = 0; i < 80; i++) send_bit(fr[i]);
  endtask

  task automatic finish_frame();
    ltc_in = ~ltc_in;
    edge_cyc = cyc;
    tick(8);
  endtask

  task automatic rnd_tc(output int h, output int m, output int s,
                        output int f);
    h = int'($urandom_range(23, 0));
    m = int'($urandom_range(59, 0));
    s = int'($urandom_range(59, 0));
    f = int'($urandom_range(29, 0));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ltc_in  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(3);
      ltc_in = ~ltc_in;
    end
    checks++;
    if (obs() !== 27'd0) begin
      fails++;
      $display("FAIL reset_tc: got %h expected 0", obs());
    end
    checks++;
    if (locked !== 1'b0 || frame_valid !== 1'b0 || fv_cnt != 0) begin
      fails++;
      $display("FAIL reset_flags: got lock=%b fv=%b n=%0d expected 0 0 0",
               locked, frame_valid, fv_cnt);
    end
`ifdef LTC_USER_BITS_EN
    checks++;
    if (user_bits !== 32'd0) begin
      fails++;
      $display("FAIL reset_ub: got %h expected 0", user_bits);
    end
`endif
    ltc_in = 1'b0;
    tick(4);
    reset_n = 1'b1;
    tick(4);
    checks++;
    if (obs() !== 27'd0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got %h lock=%b expected 0 0",
               obs(), locked);
    end
  endtask

  task automatic test_decode();
    int n0;
    int lat;
    n0 = fv_cnt;
    send_frame(mk_frame(12, 34, 56, 24, 1'b0, 32'h0));
    finish_frame();
    last_exp = tcv(12, 34, 56, 24, 1'b0);
    checks++;
    if (fv_cnt != n0 + 1) begin
      fails++;
      $display("FAIL decode_count: got %0d expected %0d", fv_cnt - n0, 1);
    end
    checks++;
    if (obs() !== last_exp) begin
      fails++;
      $display("FAIL decode_tc: got %h expected %h", obs(), last_exp);
    end
    checks++;
    if (tc_hours !== 6'h12 || tc_min !== 7'h34 ||
        tc_sec !== 7'h56 || tc_frames !== 6'h24) begin
      fails++;
      $display("FAIL decode_fields: got %h:%h:%h:%h expected 12:34:56:24",
               tc_hours, tc_min, tc_sec, tc_frames);
    end
    checks++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL decode_lock: got %b expected 1", locked);
    end
    lat = (fv_cyc.size() > 0) ? fv_cyc[$] - edge_cyc : 99;
    checks++;
    if (lat < 1 || lat > 5) begin
      fails++;
      $display("FAIL decode_latency: got %0d expected 1..5", lat);
    end
  endtask

  task automatic test_timeout();
    tick(32);
    checks++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL timeout_early: got lock=%b expected 1", locked);
    end
    tick(32);
    checks++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL timeout_lock: got lock=%b expected 0", locked);
    end
    checks++;
    if (obs() !== last_exp) begin
      fails++;
      $display("FAIL timeout_hold: got %h expected %h", obs(), last_exp);
    end
  endtask

  task automatic test_continuity();
    int n0;
    int gap;
    n0 = fv_cnt;
    send_frame(mk_frame(0, 0, 0, 0, 1'b0, 32'h0));
    send_frame(mk_frame(0, 0, 0, 1, 1'b0, 32'h0));
    finish_frame();
    last_exp = tcv(0, 0, 0, 1, 1'b0);
    checks++;
    if (fv_cnt != n0 + 2) begin
      fails++;
      $display("FAIL cont_count: got %0d expected 2", fv_cnt - n0);
    end
    gap = (fv_cyc.size() > 1) ? fv_cyc[$] - fv_cyc[$-1] : 0;
    checks++;
    if (gap != 1280) begin
      fails++;
      $display("FAIL cont_gap: got %0d expected 1280", gap);
    end
    checks++;
    if (tc_frames !== 6'h01 || obs() !== last_exp) begin
      fails++;
      $display("FAIL cont_tc: got %h expected %h", obs(), last_exp);
    end
    checks++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL cont_lock: got %b expected 1", locked);
    end
  endtask

  task automatic test_decode_error();
    int h, m, s, f, n0;
    logic [26:0] ea, ec;
    logic [79:0] fb;
    n0 = fv_cnt;
    rnd_tc(h, m, s, f);
    ea = tcv(h, m, s, f, 1'b0);
    send_frame(mk_frame(h, m, s, f, 1'b0, 32'h0));
    rnd_tc(h, m, s, f);
    fb = mk_frame(h, m, s, f, 1'b0, 32'h0);
    for (int i = 0; i < 70; i++) send_bit(fb[i]);
    ltc_in = ~ltc_in;
    tick(8);
    ltc_in = ~ltc_in;
    tick(16);
    send_bit(fb[71]);
    checks++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL err_lock: got %b expected 0", locked);
    end
    checks++;
    if (obs() !== ea) begin
      fails++;
      $display("FAIL err_hold: got %h expected %h", obs(), ea);
    end
    for (int i = 72; i < 80; i++) send_bit(fb[i]);
    rnd_tc(h, m, s, f);
    ec = tcv(h, m, s, f, 1'b0);
    send_frame(mk_frame(h, m, s, f, 1'b0, 32'h0));
    finish_frame();
    last_exp = ec;
    checks++;
    if (fv_cnt != n0 + 2) begin
      fails++;
      $display("FAIL err_count: got %0d expected 2", fv_cnt - n0);
    end
    checks++;
    if (cap.size() < 2 || cap[$-1] !== ea || cap[$] !== ec) begin
      fails++;
      $display("FAIL err_frames: got %h expected %h then %h",
               obs(), ea, ec);
    end
    checks++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL err_relock: got %b expected 1", locked);
    end
  endtask

  task automatic test_bcd_reject();
    int h, m, s, f, n0;
    logic [26:0] ep;
    logic [79:0] fq;
    n0 = fv_cnt;
    rnd_tc(h, m, s, f);
    ep = tcv(h, m, s, f, 1'b1);
    send_frame(mk_frame(h, m, s, f, 1'b1, 32'h89ABCDEF));
    rnd_tc(h, m, s, f);
    fq = mk_frame(h, m, s, f, 1'b0, 32'h0);
    fq[19:16] = 4'hA;
    for (int i = 0; i < 40; i++) send_bit(fq[i]);
    checks++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL bcd_prelock: got %b expected 1", locked);
    end
    for (int i = 40; i < 80; i++) send_bit(fq[i]);
    finish_frame();
    last_exp = ep;
    checks++;
    if (fv_cnt != n0 + 1) begin
      fails++;
      $display("FAIL bcd_count: got %0d expected 1", fv_cnt - n0);
    end
    checks++;
    if (locked !== 1'b0) begin
      fails++;
      $display("FAIL bcd_lock: got %b expected 0", locked);
    end
    checks++;
    if (obs() !== ep) begin
      fails++;
      $display("FAIL bcd_hold: got %h expected %h", obs(), ep);
    end
`ifdef LTC_USER_BITS_EN
    checks++;
    if (user_bits !== 32'h89ABCDEF) begin
      fails++;
      $display("FAIL bcd_ub: got %h expected 89abcdef", user_bits);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    int h, m, s, f, n0;
    logic [79:0] fr;
    logic [26:0] es;
    rnd_tc(h, m, s, f);
    fr = mk_frame(h, m, s, f, 1'b0, 32'h0);
    for (int i = 0; i < 40; i++) send_bit(fr[i]);
    reset_n = 1'b0;
    tick(3);
    checks++;
    if (obs() !== 27'd0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_clear: got %h lock=%b expected 0 0",
               obs(), locked);
    end
    reset_n = 1'b1;
    tick(100);
    n0 = fv_cnt;
    rnd_tc(h, m, s, f);
    es = tcv(h, m, s, f, 1'b0);
    send_frame(mk_frame(h, m, s, f, 1'b0, 32'h0));
    finish_frame();
    last_exp = es;
    checks++;
    if (fv_cnt != n0 + 1 || obs() !== es) begin
      fails++;
      $display("FAIL rstmid_frame: got n=%0d %h expected n=1 %h",
               fv_cnt - n0, obs(), es);
    end
    checks++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_lock: got %b expected 1", locked);
    end
  endtask

  task automatic test_back_to_back();
    int h, m, s, f, base, n0, gap;
    bit df;
    logic [26:0] ex[6];
    base = cap.size();
    n0   = fv_cnt;
    for (int k = 0; k < 6; k++) begin
      rnd_tc(h, m, s, f);
      df = bit'($urandom_range(1, 0));
      ex[k] = tcv(h, m, s, f, df);
      send_frame(mk_frame(h, m, s, f, df, 32'h0));
    end
    finish_frame();
    last_exp = ex[5];
    checks++;
    if (fv_cnt != n0 + 6) begin
      fails++;
      $display("FAIL b2b_count: got %0d expected 6", fv_cnt - n0);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (base + k >= cap.size()) begin
        fails++;
        $display("FAIL b2b_frame%0d: got none expected %h", k, ex[k]);
      end else if (cap[base + k] !== ex[k]) begin
        fails++;
        $display("FAIL b2b_frame%0d: got %h expected %h",
                 k, cap[base + k], ex[k]);
      end
    end
    gap = (fv_cyc.size() > 5) ? fv_cyc[$] - fv_cyc[$-5] : 0;
    checks++;
    if (gap != 5 * 1280) begin
      fails++;
      $display("FAIL b2b_gap: got %0d expected %0d", gap, 5 * 1280);
    end
    checks++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL b2b_lock: got %b expected 1", locked);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    ltc_in   = 1'b0;
    last_exp = 27'd0;
    test_reset();
    test_decode();
    test_timeout();
    tick(10);
    test_continuity();
    tick(80);
    test_decode_error();
    tick(80);
    test_bcd_reject();
    tick(80);
    test_reset_midframe();
    tick(80);
    test_back_to_back();
    tick(10);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
